// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder used as the serial adder's datapath cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock,
// LSB first, producing a registered WIDTH-bit sum and carry-out.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum_reg;
    logic             carry_reg;

    logic             cell_sum;
    logic             cell_carry;
    logic [WIDTH-1:0] psum_next;

    fa_cell u_fa_cell (
        .a     (a_reg[0]),
        .b     (b_reg[0]),
        .c_in  (carry_reg),
        .sum   (cell_sum),
        .c_out (cell_carry)
    );

    // New sum bit enters at the MSB; the cast also covers WIDTH == 1.
    assign psum_next = WIDTH'({cell_sum, psum_reg} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        psum_reg  <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    psum_reg  <= psum_next;
                    carry_reg <= cell_carry;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Last bit: publish result on the same edge it is computed.
                    if (cnt_reg == LAST_BIT) begin
                        sum       <= psum_next;
                        c_out     <= cell_carry;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       c_in1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       c_out1;

    int checks;
    int errors;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .c_in  (c_in1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (c_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation on the 8-bit DUT; returns edges from capture to done (-1 on timeout).
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output int cycles);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, c_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h c_out=%b exp all 0", busy, done, sum, c_out);
        end
        checks++;
        if ({busy1, done1, sum1, c_out1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs_w1 got %b exp 0000", {busy1, done1, sum1, c_out1});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int cyc;
        a = 8'hFF; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        cyc = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = n;
                break;
            end
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 8", cyc);
        end
        checks++;
        if (sum !== 8'h00 || c_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got sum=%h c_out=%b busy=%b exp sum=00 c_out=1 busy=0", sum, c_out, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b exp 0", done);
        end
    endtask

    task automatic test_hold;
        int cyc;
        run_op8(8'h5A, 8'hA5, 1'b1, cyc);
        checks++;
        if (cyc !== 8 || sum !== 8'h00 || c_out !== 1'b1) begin
            errors++;
            $display("FAIL hold_first got cyc=%0d sum=%h c_out=%b exp cyc=8 sum=00 c_out=1", cyc, sum, c_out);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'hEE; b = 8'hEE; c_in = 1'b1;
        cyc = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 4) begin
                checks++;
                if (sum !== 8'h00 || c_out !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_during_run got sum=%h c_out=%b exp sum=00 c_out=1", sum, c_out);
                end
            end
            if (done) begin
                cyc = n;
                break;
            end
        end
        checks++;
        if (cyc !== 8 || sum !== 8'h46 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_second got cyc=%0d sum=%h c_out=%b exp cyc=8 sum=46 c_out=0", cyc, sum, c_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int dones;
        int first;
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 16; n++) begin
            if (n == 3) begin
                a = 8'h01; b = 8'h00; start = 1'b1;
            end
            @(posedge clk); #1;
            if (n == 3) start = 1'b0;
            if (busy && done) begin
                checks++;
                errors++;
                $display("FAIL busy_done_overlap at edge %0d got both high exp exclusive", n);
            end
            if (done) begin
                dones++;
                if (first < 0) first = n;
                checks++;
                if (sum !== 8'h30 || c_out !== 1'b0) begin
                    errors++;
                    $display("FAIL start_ignored_result got sum=%h c_out=%b exp sum=30 c_out=0", sum, c_out);
                end
            end
        end
        checks++;
        if (dones !== 1 || first !== 8) begin
            errors++;
            $display("FAIL start_ignored_pulses got dones=%0d first=%0d exp dones=1 first=8", dones, first);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        int cyc;
        a = 8'h55; b = 8'h22; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b sum=%h c_out=%b exp all 0", busy, done, sum, c_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d pulses exp 0", dones);
        end
        run_op8(8'h03, 8'h04, 1'b0, cyc);
        checks++;
        if (cyc !== 8 || sum !== 8'h07 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fresh got cyc=%0d sum=%h c_out=%b exp cyc=8 sum=07 c_out=0", cyc, sum, c_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width1;
        int cyc;
        a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                cyc = n;
                break;
            end
        end
        checks++;
        if (cyc !== 1 || sum1 !== 1'b1 || c_out1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL width1 got cyc=%0d sum=%b c_out=%b busy=%b exp cyc=1 sum=1 c_out=1 busy=0",
                     cyc, sum1, c_out1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL width1_done_pulse got %b exp 0", done1);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] expected;
        int edge_cnt;
        int last_done;
        bit found;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        expected = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
        start = 1'b1;
        @(posedge clk); #1;
        edge_cnt = 0;
        last_done = 0;
        for (int i = 0; i < 1000; i++) begin
            found = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(posedge clk); #1;
                edge_cnt++;
                if (done) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL b2b_timeout op %0d got no done exp done within 20 edges", i);
                break;
            end
            if ({c_out, sum} !== expected) begin
                errors++;
                $display("FAIL b2b_result op %0d got %h exp %h", i, {c_out, sum}, expected);
            end
            checks++;
            if ((edge_cnt - last_done) !== ((i == 0) ? 8 : 10)) begin
                errors++;
                $display("FAIL b2b_spacing op %0d got %0d exp %0d", i, edge_cnt - last_done,
                         (i == 0) ? 8 : 10);
            end
            last_done = edge_cnt;
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            expected = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
            if (i == 999) start = 1'b0;
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_hold();
        test_start_ignored();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are WIDTH >= 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have ports a and b, each input, WIDTH bits: operands, captured on the accepted start edge.
REQ-006 SHALL have port c_in, input, 1 bit: carry-in, captured with the operands.
REQ-007 SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-009 SHALL have port sum, output, WIDTH bits: result, registered.
REQ-010 SHALL have port c_out, output, 1 bit: final carry-out, registered.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at rising edge k, load a, b and c_in into operand shift registers and the carry flop, clear the bit counter and enter RUN.
REQ-013 SHALL, on each edge in RUN, feed bit 0 of both shift registers plus the carry flop through one 1-bit full-adder cell, shift the operand registers right, shift the sum bit into the MSB of the partial-sum register and store the cell carry.
REQ-014 SHALL remain in RUN for exactly WIDTH edges (k+1..k+WIDTH), then enter DONE, writing partial sum to sum and final carry to c_out on edge k+WIDTH.
REQ-015 SHALL assert done only in DONE (exactly one cycle) and return to IDLE on the next edge.
REQ-016 SHALL assert busy in RUN only; busy and done are never high together.
REQ-017 SHALL ignore start in RUN and DONE; an operation already running is never restarted or corrupted.
REQ-018 SHALL ignore changes on a, b and c_in after capture.
REQ-019 SHALL hold sum and c_out from one DONE until the next DONE, so they are unchanged through IDLE and RUN.
REQ-020 SHALL produce sum and c_out equal to the (WIDTH+1)-bit value a + b + c_in, with c_out as the MSB.
REQ-021 SHALL size the bit counter to $clog2(WIDTH+1) bits and never let it wrap within an operation.
REQ-022 SHALL accept back-to-back operations with start held high, giving a new start edge k+WIDTH+2 with no further idle cycle.

Reset
REQ-023 SHALL, while rst_n=0, immediately force state to IDLE and set busy=0, done=0, sum=0, c_out=0, the counter, the shift registers and the carry flop to 0.
REQ-024 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; the first start after release begins a fresh operation.

Structure
REQ-025 SHALL take the state enum (IDLE, RUN, DONE) and the default WIDTH constant from the shared package adder_pkg.
REQ-026 SHALL instantiate exactly one sub-module, fa_cell, a purely combinational 1-bit full adder (a, b, c_in -> sum, c_out); all sequential logic stays in serial_adder.

Verification
REQ-027 SHALL cover this scenario with WIDTH=8: a=0xFF, b=0x01, c_in=0 -> done at cycle k+WIDTH+1, sum=0x00, c_out=1.
REQ-028 SHALL cover: a=0x5A, b=0xA5, c_in=1 -> sum=0x00, c_out=1; then a=0x12, b=0x34, c_in=0 -> sum=0x46, c_out=0, with the first result held until the second done.
REQ-029 SHALL cover: start pulsed with a=0x01 at edge k+3 during RUN of a=0x10, b=0x20 -> ignored, result is sum=0x30, exactly one done pulse.
REQ-030 SHALL cover: rst_n pulled low at edge k+4 of RUN -> busy=0, done=0, sum=0x00, c_out=0 immediately, no done pulse; then a=0x03, b=0x04 -> sum=0x07.
REQ-031 SHALL cover WIDTH=1 with a=1, b=1, c_in=1 -> sum=1, c_out=1, done high on cycle k+2.
REQ-032 SHALL cover 1000 random operands with start held high, comparing every result against a + b + c_in and checking done spacing of WIDTH+2 cycles.
